varray: RTL and testbench
=========================

Name: varray

Overview:
- Virtual (run-length) array: each write fills a contiguous range of virtual addresses with one element value in a single cycle.
- Stored internally as a small segment table instead of a dense memory.
- Reads return the value covering the requested address, one cycle later.
- Tracks the virtual array length: highest written address + 1. Used by FIFO/core logic to hold sparse, repeated-value vectors cheaply.

Parameters:
- VIRTUAL_ELEMENT_WIDTH, 4, bit width of one stored element.
- VIRTUAL_ADDR_BITS, 16, width of virtual addresses and of varray_len.
- NUM_SEGMENTS, 16, number of segment-table entries (maximum distinct writes retained).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- we  input  1  write enable.
- write_addr  input  VIRTUAL_ADDR_BITS  first virtual address of the write range.
- write_addr_len  input  4  number of consecutive addresses written (0..15).
- dat_w  input  VIRTUAL_ELEMENT_WIDTH  value written to every address in the range.
- re  input  1  read enable.
- read_addr  input  VIRTUAL_ADDR_BITS  virtual address to read.
- dat_r  output  VIRTUAL_ELEMENT_WIDTH  registered read data.
- varray_len  output  VIRTUAL_ADDR_BITS  registered virtual length.

Behaviour:
- Reset (synchronous, active-high):
  - all segments invalid; segment count = 0.
  - dat_r = 0; varray_len = 0.
- Write (we=1, write_addr_len != 0, table not full):
  - On the clock edge, append segment {start=write_addr, len=write_addr_len, value=dat_w} at index = count; count increments.
- Ignored writes (no state change at all):
  - write_addr_len == 0 is a no-op.
  - A write when count == NUM_SEGMENTS is dropped; varray_len is also unchanged.
- varray_len update, on the same edge as an accepted write:
  - varray_len <= max(varray_len, write_addr + write_addr_len).
  - Sum is computed at VIRTUAL_ADDR_BITS+1 bits and saturates at 2^VIRTUAL_ADDR_BITS-1.
  - The new value is visible immediately after that edge.
- Segment coverage: segment covers address a iff start <= a < start+len.
  - Compare at VIRTUAL_ADDR_BITS+1 bits; ranges do not wrap past the top address.
- Read (re=1):
  - On the clock edge, dat_r <= value of the highest-index (newest) valid segment covering read_addr.
  - dat_r <= 0 if no segment covers read_addr.
  - Latency is one cycle: data is valid after the edge on which re/read_addr were sampled.
- re=0: dat_r holds its previous value.
- Write visibility: a segment written on edge N is readable by a read sampled on edge N+1.
- Simultaneous read and write on the same edge: read-before-write; the read does not see the segment being written that cycle.
- Overlapping writes: the newest segment wins at overlapping addresses; older segments still supply non-overlapped addresses.
- Reset has priority over we/re on the same edge.
- Fully synthesizable; no combinational path from inputs to outputs.

Decomposition:
- Package varray_pkg holds:
  - the segment struct typedef (valid, start, len, value);
  - the default width constants;
  - the length-field width (4).
- One natural sub-module, varray_seg_match:
  - combinational priority lookup over the segment table;
  - returns the hit flag and value for read_addr.
- Top level keeps the segment registers, count, varray_len and the dat_r register.

Test Plan:
- Reset then idle: dat_r == 0 and varray_len == 0; a read of address 5 returns 0.
- Basic fill: write addr 0, len 2, dat 12.
  - Next cycle read 0 -> dat_r == 12 after one edge.
  - Read 1 -> 12.
  - varray_len == 2.
- Sparse extend: after the above, write addr 10, len 3, dat 6 -> varray_len == 13 right after the write edge.
  - Reads of 10, 11, 12 each return 6.
  - Read of 13 returns 0; read of 5 returns 0.
- Overlap priority: write (4, len 4, 3) then (6, len 4, 9).
  - Reads 4,5 -> 3; reads 6..9 -> 9.
  - varray_len == 10.
- Edge cases:
  - len 0 write leaves varray_len and reads unchanged.
  - Write at addr 0xFFF8, len 15 -> varray_len saturates at 0xFFFF.
  - Same-cycle read of a just-written address returns the old value.
- Full table: 16 accepted writes, then a 17th -> 17th ignored, varray_len unchanged.
  - After reset, all reads return 0 and varray_len == 0.

Source files
------------

// File: rtl/varray_pkg.sv
// Shared types and default widths for the run-length virtual array.
package varray_pkg;

  localparam int DEF_ELEM_W    = 4;
  localparam int DEF_ADDR_BITS = 16;
  localparam int DEF_NUM_SEGS  = 16;
  localparam int SEG_LEN_BITS  = 4;

  // One run: 'len' consecutive addresses starting at 'start' all hold 'value'.
  typedef struct packed {
    logic                     valid;
    logic [DEF_ADDR_BITS-1:0] start;
    logic [SEG_LEN_BITS-1:0]  len;
    logic [DEF_ELEM_W-1:0]    value;
  } seg_t;

  // Coverage test done one bit wider so a run near the top address never wraps.
  function automatic logic seg_covers(input seg_t s, input logic [DEF_ADDR_BITS-1:0] a);
    logic [DEF_ADDR_BITS:0] lo;
    logic [DEF_ADDR_BITS:0] hi;
    logic [DEF_ADDR_BITS:0] aw;
    lo = {1'b0, s.start};
    hi = lo + (DEF_ADDR_BITS+1)'(s.len);
    aw = {1'b0, a};
    return s.valid && (aw >= lo) && (aw < hi);
  endfunction

endpackage

// File: rtl/varray_seg_match.sv
// Priority lookup over the segment table: the highest-index covering run wins.
module varray_seg_match
  import varray_pkg::*;
#(
  parameter int NUM_SEGMENTS = DEF_NUM_SEGS
) (
  input  seg_t                     segs_i [NUM_SEGMENTS],
  input  logic [DEF_ADDR_BITS-1:0] addr_i,
  output logic                     hit_o,
  output logic [DEF_ELEM_W-1:0]    value_o
);

  // Scan oldest to newest so later (newer) hits overwrite earlier ones.
  always_comb begin
    hit_o   = 1'b0;
    value_o = '0;
    for (int i = 0; i < NUM_SEGMENTS; i++) begin
      if (seg_covers(segs_i[i], addr_i)) begin
        hit_o   = 1'b1;
        value_o = segs_i[i].value;
      end
    end
  end

endmodule

// File: rtl/varray.sv
// Virtual run-length array: each write appends one run to a small segment
// table; reads return the newest covering value one cycle later.
// Element and address widths are carried by seg_t, so only the package
// defaults are supported for those two parameters.
module varray
  import varray_pkg::*;
#(
  parameter int VIRTUAL_ELEMENT_WIDTH = DEF_ELEM_W,
  parameter int VIRTUAL_ADDR_BITS     = DEF_ADDR_BITS,
  parameter int NUM_SEGMENTS          = DEF_NUM_SEGS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             we,
  input  logic [VIRTUAL_ADDR_BITS-1:0]     write_addr,
  input  logic [SEG_LEN_BITS-1:0]          write_addr_len,
  input  logic [VIRTUAL_ELEMENT_WIDTH-1:0] dat_w,
  input  logic                             re,
  input  logic [VIRTUAL_ADDR_BITS-1:0]     read_addr,
  output logic [VIRTUAL_ELEMENT_WIDTH-1:0] dat_r,
  output logic [VIRTUAL_ADDR_BITS-1:0]     varray_len
);

  localparam int CNT_W = $clog2(NUM_SEGMENTS + 1);
  localparam int AB    = VIRTUAL_ADDR_BITS;

  seg_t                             segs_q [NUM_SEGMENTS];
  seg_t                             segs_d [NUM_SEGMENTS];
  logic [CNT_W-1:0]                 count_q, count_d;
  logic [VIRTUAL_ELEMENT_WIDTH-1:0] dat_r_q, dat_r_d;
  logic [AB-1:0]                    len_q, len_d;

  logic                             wr_accept;
  logic [AB:0]                      wr_end;
  logic [AB-1:0]                    wr_end_sat;
  logic                             rd_hit;
  logic [VIRTUAL_ELEMENT_WIDTH-1:0] rd_value;

  // Lookup sees only registered segments, giving read-before-write ordering.
  varray_seg_match #(
    .NUM_SEGMENTS(NUM_SEGMENTS)
  ) u_seg_match (
    .segs_i (segs_q),
    .addr_i (read_addr),
    .hit_o  (rd_hit),
    .value_o(rd_value)
  );

  // Next-state: append accepted writes, grow the length, capture read data.
  always_comb begin
    segs_d     = segs_q;
    count_d    = count_q;
    len_d      = len_q;
    dat_r_d    = dat_r_q;
    wr_accept  = we && (write_addr_len != '0) && (count_q != CNT_W'(NUM_SEGMENTS));
    wr_end     = {1'b0, write_addr} + (AB+1)'(write_addr_len);
    wr_end_sat = wr_end[AB] ? '1 : wr_end[AB-1:0];

    if (re) begin
      dat_r_d = rd_hit ? rd_value : '0;
    end

    if (wr_accept) begin
      for (int i = 0; i < NUM_SEGMENTS; i++) begin
        if (count_q == CNT_W'(i)) begin
          segs_d[i] = '{valid: 1'b1, start: write_addr, len: write_addr_len, value: dat_w};
        end
      end
      count_d = count_q + CNT_W'(1);
      if (wr_end_sat > len_q) begin
        len_d = wr_end_sat;
      end
    end
  end

  // State registers with synchronous reset taking priority over we/re.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SEGMENTS; i++) begin
        segs_q[i] <= '0;
      end
      count_q <= '0;
      len_q   <= '0;
      dat_r_q <= '0;
    end else begin
      segs_q  <= segs_d;
      count_q <= count_d;
      len_q   <= len_d;
      dat_r_q <= dat_r_d;
    end
  end

  assign dat_r      = dat_r_q;
  assign varray_len = len_q;

endmodule

// File: tb/tb_varray.sv
// Directed bench for varray: a vector table of single-cycle operations with
// hand-computed results, plus a table-full sequence.
module tb_varray;

  typedef struct {
    logic        rst;
    logic        we;
    logic [15:0] wa;
    logic [3:0]  wl;
    logic [3:0]  wd;
    logic        re;
    logic [15:0] ra;
    logic [3:0]  exp_dat;
    logic [15:0] exp_len;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, we, re;
  logic [15:0] write_addr, read_addr;
  logic [3:0]  write_addr_len, dat_w;
  logic [3:0]  dat_r;
  logic [15:0] varray_len;

  int n_vec  = 0;
  int n_fail = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  varray dut (
    .clk           (clk),
    .reset         (reset),
    .we            (we),
    .write_addr    (write_addr),
    .write_addr_len(write_addr_len),
    .dat_w         (dat_w),
    .re            (re),
    .read_addr     (read_addr),
    .dat_r         (dat_r),
    .varray_len    (varray_len)
  );

  function automatic vec_t mk(logic r, logic w, logic [15:0] wa, logic [3:0] wl,
                              logic [3:0] wd, logic rd, logic [15:0] ra,
                              logic [3:0] ed, logic [15:0] el);
    vec_t v;
    v.rst = r; v.we = w; v.wa = wa; v.wl = wl; v.wd = wd;
    v.re = rd; v.ra = ra; v.exp_dat = ed; v.exp_len = el;
    return v;
  endfunction

  // Drive one cycle of inputs at the falling edge, then sample after the rise.
  task automatic step(input logic r, input logic w, input logic [15:0] wa,
                      input logic [3:0] wl, input logic [3:0] wd,
                      input logic rd, input logic [15:0] ra);
    @(negedge clk);
    reset = r; we = w; write_addr = wa; write_addr_len = wl; dat_w = wd;
    re = rd; read_addr = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int idx, input logic [3:0] ed,
                     input logic [15:0] el);
    n_vec++;
    if (dat_r !== ed || varray_len !== el) begin
      n_fail++;
      $display("FAIL %s[%0d]: dat_r=%0h len=%0h, expected dat_r=%0h len=%0h",
               tag, idx, dat_r, varray_len, ed, el);
    end
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; re = 1'b0;
    write_addr = '0; write_addr_len = '0; dat_w = '0; read_addr = '0;

    //          rst we  waddr     wl  wd  re  raddr     dat  len
    vq.push_back(mk(1, 0, 16'd0,    0,  0,  0, 16'd0,    0, 16'd0));
    vq.push_back(mk(0, 0, 16'd0,    0,  0,  1, 16'd5,    0, 16'd0));
    vq.push_back(mk(0, 1, 16'd0,    2, 12,  0, 16'd0,    0, 16'd2));
    vq.push_back(mk(0, 0, 16'd0,    0,  0,  1, 16'd0,   12, 16'd2));
    vq.push_back(mk(0, 0, 16'd0,    0,  0,  1, 16'd1,   12, 16'd2));
    vq.push_back(mk(0, 1, 16'd10,   3,  6,  0, 16'd0,   12, 16'd13));
    vq.push_back(mk(0, 0, 16'd0,    0,  0,  1, 16'd10,   6, 16'd13));
    vq.push_back(mk(0, 0, 16'd0,    0,  0,  1, 16'd11,   6, 16'd13));
    vq.push_back(mk(0, 0, 16'd0,    0,  0,  1, 16'd12,   6, 16'd13));
    vq.push_back(mk(0, 0, 16'd0,    0,  0,  1, 16'd13,   0, 16'd13));
    vq.push_back(mk(0, 0, 16'd0,    0,  0,  1, 16'd5,    0, 16'd13));
    // fresh table: overlapping runs
    vq.push_back(mk(1, 0, 16'd0,    0,  0,  0, 16'd0,    0, 16'd0));
    vq.push_back(mk(0, 1, 16'd4,    4,  3,  0, 16'd0,    0, 16'd8));
    vq.push_back(mk(0, 1, 16'd6,    4,  9,  0, 16'd0,    0, 16'd10));
    vq.push_back(mk(0, 0, 16'd0,    0,  0,  1, 16'd4,    3, 16'd10));
    vq.push_back(mk(0, 0, 16'd0,    0,  0,  1, 16'd5,    3, 16'd10));
    vq.push_back(mk(0, 0, 16'd0,    0,  0,  1, 16'd6,    9, 16'd10));
    vq.push_back(mk(0, 0, 16'd0,    0,  0,  1, 16'd7,    9, 16'd10));
    vq.push_back(mk(0, 0, 16'd0,    0,  0,  1, 16'd8,    9, 16'd10));
    vq.push_back(mk(0, 0, 16'd0,    0,  0,  1, 16'd9,    9, 16'd10));
    vq.push_back(mk(0, 0, 16'd0,    0,  0,  1, 16'd3,    0, 16'd10));
    vq.push_back(mk(0, 0, 16'd0,    0,  0,  1, 16'd10,   0, 16'd10));
    // zero-length writes change nothing; re=0 holds dat_r
    vq.push_back(mk(0, 1, 16'd100,  0,  5,  1, 16'd100,  0, 16'd10));
    vq.push_back(mk(0, 0, 16'd0,    0,  0,  1, 16'd6,    9, 16'd10));
    vq.push_back(mk(0, 1, 16'd100,  0,  5,  0, 16'd0,    9, 16'd10));
    // same-edge read returns the pre-write value
    vq.push_back(mk(0, 1, 16'd20,   1,  7,  1, 16'd20,   0, 16'd21));
    vq.push_back(mk(0, 0, 16'd0,    0,  0,  1, 16'd20,   7, 16'd21));
    vq.push_back(mk(0, 1, 16'd6,    1,  1,  1, 16'd6,    9, 16'd21));
    vq.push_back(mk(0, 0, 16'd0,    0,  0,  1, 16'd6,    1, 16'd21));
    vq.push_back(mk(0, 0, 16'd0,    0,  0,  1, 16'd7,    9, 16'd21));
    // run past the top address: length saturates, no wrap to low addresses
    vq.push_back(mk(0, 1, 16'hFFF8, 15, 5,  0, 16'd0,    9, 16'hFFFF));
    vq.push_back(mk(0, 0, 16'd0,    0,  0,  1, 16'hFFFF, 5, 16'hFFFF));
    vq.push_back(mk(0, 0, 16'd0,    0,  0,  1, 16'hFFF7, 0, 16'hFFFF));
    vq.push_back(mk(0, 0, 16'd0,    0,  0,  1, 16'hFFF8, 5, 16'hFFFF));
    vq.push_back(mk(0, 0, 16'd0,    0,  0,  1, 16'd0,    0, 16'hFFFF));
    // reset wins over a same-edge write and read
    vq.push_back(mk(1, 1, 16'd0,    5,  4,  1, 16'd0,    0, 16'd0));
    vq.push_back(mk(0, 0, 16'd0,    0,  0,  1, 16'd0,    0, 16'd0));

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].we, vq[i].wa, vq[i].wl, vq[i].wd, vq[i].re, vq[i].ra);
      chk("vec", i, vq[i].exp_dat, vq[i].exp_len);
    end

    // Fill all 16 segments with one-address runs, then overflow.
    step(1, 0, 16'd0, 4'd0, 4'd0, 0, 16'd0);
    chk("full_rst", 0, 4'd0, 16'd0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 16'(i), 4'd1, 4'(i), 0, 16'd0);
      chk("full_wr", i, 4'd0, 16'(i + 1));
    end
    step(0, 1, 16'd100, 4'd5, 4'd3, 0, 16'd0);
    chk("full_drop", 0, 4'd0, 16'd16);
    step(0, 0, 16'd0, 4'd0, 4'd0, 1, 16'd100);
    chk("full_rd", 100, 4'd0, 16'd16);
    step(0, 0, 16'd0, 4'd0, 4'd0, 1, 16'd15);
    chk("full_rd", 15, 4'd15, 16'd16);
    step(0, 0, 16'd0, 4'd0, 4'd0, 1, 16'd3);
    chk("full_rd", 3, 4'd3, 16'd16);
    step(1, 0, 16'd0, 4'd0, 4'd0, 0, 16'd0);
    chk("full_rst", 1, 4'd0, 16'd0);
    for (int i = 0; i < 16; i += 5) begin
      step(0, 0, 16'd0, 4'd0, 4'd0, 1, 16'(i));
      chk("post_rst_rd", i, 4'd0, 16'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
